hangman_engine: RTL and testbench

HANGMAN_ENGINE -- requirements
Module: hangman_engine

---
 rtl/hangman_engine.sv | 219 +++++++++++++++++++++
 tb/tb_hangman_engine.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hangman_engine.sv
// -----------------------------------------------------------------------------
// hangman_engine
//
// Multi-player hangman referee. A secret word is loaded, then players take
// turns guessing uppercase letters. Each accepted guess is scored one cycle
// later (CHECK), updating the revealed mask, hit/miss counters and the
// guessed-letter bitmap, and the game ends in DONE on a full reveal (win) or
// on reaching MAX_MISS misses (lose).
//
// Handshake: a guess transfers on a clock edge where guess_valid && guess_ready
// are both high. guess_ready is high only in PLAY. A transferred guess that
// fails the checks (wrong player, or not 'A'..'Z') pulses reject on the next
// cycle and changes nothing else. A guess offered while guess_ready is low is
// ignored silently.
//
// Ports
//   clk           clock, rising edge
//   nRst          synchronous reset, active HIGH (1 = reset)
//   word_load     1-cycle pulse: latch word_in and start a new game
//   word_in       secret word, character 0 in bits [7:0]
//   guess_valid   guess offered this cycle
//   guess_player  index of the player making the guess
//   guess_char    guessed ASCII character
//   guess_ready   engine accepts a guess this cycle
//   turn          index of the player whose guess is expected
//   revealed      bit i set = character i revealed
//   miss_count    misses in the current game
//   hit_count     hits in the current game (saturates at 255)
//   hit/miss/dup/reject  1-cycle result pulses
//   win/lose/winner      game result, held while in DONE
//   state_dbg     current FSM state (0 IDLE, 1 PLAY, 2 CHECK, 3 DONE)
// -----------------------------------------------------------------------------
module hangman_engine #(
    parameter int WORD_LEN    = 5,
    parameter int MAX_MISS    = 6,
    parameter int NUM_PLAYERS = 2,
    localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1,
    localparam int MW = $clog2(MAX_MISS + 1)
) (
    input  logic                  clk,
    input  logic                  nRst,
    input  logic                  word_load,
    input  logic [8*WORD_LEN-1:0] word_in,
    input  logic                  guess_valid,
    input  logic [PW-1:0]         guess_player,
    input  logic [7:0]            guess_char,
    output logic                  guess_ready,
    output logic [PW-1:0]         turn,
    output logic [WORD_LEN-1:0]   revealed,
    output logic [MW-1:0]         miss_count,
    output logic [7:0]            hit_count,
    output logic                  hit,
    output logic                  miss,
    output logic                  dup,
    output logic                  reject,
    output logic                  win,
    output logic                  lose,
    output logic [PW-1:0]         winner,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state;
    logic [8*WORD_LEN-1:0] word_q;
    logic [25:0]           guessed;
    logic [7:0]            guess_q;
    logic [PW-1:0]         player_q;

    logic [WORD_LEN-1:0]   match;
    logic [WORD_LEN-1:0]   load_mask;
    logic [WORD_LEN-1:0]   rev_next;
    logic [4:0]            letter_idx;
    logic                  already;
    logic                  guess_ok;
    logic [PW-1:0]         turn_next;
    logic [MW-1:0]         miss_next;
    logic [7:0]            hit_next;

    // A guess while everything is already revealed (all-non-letter word)
    // would be meaningless; the engine is about to finish the game.
    assign guess_ready = (state == PLAY) && !(&revealed);
    assign state_dbg   = state;

    // 'A'..'Z' share bits [7:5] = 3'b010, so the low five bits minus one give
    // the alphabet index 0..25 for the (already validated) registered letter.
    assign letter_idx = guess_q[4:0] - 5'd1;
    assign already    = guessed[letter_idx];

    assign guess_ok = (guess_player == turn) &&
                      (guess_char >= 8'h41) && (guess_char <= 8'h5A);

    assign turn_next = (turn == PW'(NUM_PLAYERS - 1)) ? '0 : turn + PW'(1);
    assign miss_next = miss_count + MW'(1);
    assign hit_next  = (hit_count == 8'hFF) ? hit_count : hit_count + 8'd1;

    // All positions are compared against the registered letter in parallel.
    always_comb begin
        match     = '0;
        load_mask = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            match[i]     = (word_q[i*8 +: 8] == guess_q);
            load_mask[i] = !((word_in[i*8 +: 8] >= 8'h41) &&
                             (word_in[i*8 +: 8] <= 8'h5A));
        end
    end

    assign rev_next = revealed | match;

    always_ff @(posedge clk) begin
        if (nRst) begin
            state      <= IDLE;
            word_q     <= '0;
            guessed    <= '0;
            guess_q    <= '0;
            player_q   <= '0;
            turn       <= '0;
            revealed   <= '0;
            miss_count <= '0;
            hit_count  <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
            dup        <= 1'b0;
            reject     <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
            winner     <= '0;
        end else begin
            // Result pulses last a single cycle.
            hit    <= 1'b0;
            miss   <= 1'b0;
            dup    <= 1'b0;
            reject <= 1'b0;

            if (word_load) begin
                // A load overrides everything, including a guess offered in
                // the same cycle or one pending in CHECK.
                state      <= PLAY;
                word_q     <= word_in;
                guessed    <= '0;
                turn       <= '0;
                revealed   <= load_mask;
                miss_count <= '0;
                hit_count  <= '0;
                win        <= 1'b0;
                lose       <= 1'b0;
                winner     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        // Waiting for a word; guesses are ignored.
                    end

                    PLAY: begin
                        if (&revealed) begin
                            // Only reachable straight after loading a word
                            // with no letters in it.
                            state  <= DONE;
                            win    <= 1'b1;
                            winner <= '0;
                        end else if (guess_valid) begin
                            if (guess_ok) begin
                                guess_q  <= guess_char;
                                player_q <= guess_player;
                                state    <= CHECK;
                            end else begin
                                reject <= 1'b1;
                            end
                        end
                    end

                    CHECK: begin
                        if (already) begin
                            dup   <= 1'b1;
                            state <= PLAY;
                        end else begin
                            guessed[letter_idx] <= 1'b1;
                            turn                <= turn_next;
                            if (|match) begin
                                hit       <= 1'b1;
                                revealed  <= rev_next;
                                hit_count <= hit_next;
                                if (&rev_next) begin
                                    state  <= DONE;
                                    win    <= 1'b1;
                                    winner <= player_q;
                                end else begin
                                    state <= PLAY;
                                end
                            end else begin
                                miss       <= 1'b1;
                                miss_count <= miss_next;
                                if (miss_next == MW'(MAX_MISS)) begin
                                    state  <= DONE;
                                    lose   <= 1'b1;
                                    winner <= '0;
                                end else begin
                                    state <= PLAY;
                                end
                            end
                        end
                    end

                    DONE: begin
                        // Held until word_load or reset.
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hangman_engine.sv
// -----------------------------------------------------------------------------
// tb_hangman_engine
//
// Directed bench for hangman_engine with three players. Inputs are driven and
// outputs sampled 1 ns after each rising edge. A guess is offered for one
// edge (the accept edge); its result pulse is visible after the following
// edge.
// -----------------------------------------------------------------------------
module tb_hangman_engine;

    localparam int WORD_LEN    = 5;
    localparam int MAX_MISS    = 6;
    localparam int NUM_PLAYERS = 3;
    localparam int PW          = 2;
    localparam int MW          = 3;

    logic                  clk = 1'b0;
    logic                  nRst;
    logic                  word_load;
    logic [8*WORD_LEN-1:0] word_in;
    logic                  guess_valid;
    logic [PW-1:0]         guess_player;
    logic [7:0]            guess_char;
    logic                  guess_ready;
    logic [PW-1:0]         turn;
    logic [WORD_LEN-1:0]   revealed;
    logic [MW-1:0]         miss_count;
    logic [7:0]            hit_count;
    logic                  hit, miss, dup, reject;
    logic                  win, lose;
    logic [PW-1:0]         winner;
    logic [1:0]            state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    hangman_engine #(
        .WORD_LEN   (WORD_LEN),
        .MAX_MISS   (MAX_MISS),
        .NUM_PLAYERS(NUM_PLAYERS)
    ) dut (
        .clk         (clk),
        .nRst        (nRst),
        .word_load   (word_load),
        .word_in     (word_in),
        .guess_valid (guess_valid),
        .guess_player(guess_player),
        .guess_char  (guess_char),
        .guess_ready (guess_ready),
        .turn        (turn),
        .revealed    (revealed),
        .miss_count  (miss_count),
        .hit_count   (hit_count),
        .hit         (hit),
        .miss        (miss),
        .dup         (dup),
        .reject      (reject),
        .win         (win),
        .lose        (lose),
        .winner      (winner),
        .state_dbg   (state_dbg)
    );

    // ---------------- helpers ----------------
    function automatic logic [39:0] w5(input logic [7:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pulses packed as {hit, miss, dup, reject}
    task automatic chk_pulses(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, hit, miss, dup, reject}, {28'd0, exp});
    endtask

    task automatic load(input logic [39:0] w);
        word_load = 1'b1;
        word_in   = w;
        tick();
        word_load = 1'b0;
    endtask

    // Offer a guess for one edge; afterwards the engine is in CHECK (if
    // accepted) or showing reject.
    task automatic offer(input logic [PW-1:0] p, input logic [7:0] c);
        guess_valid  = 1'b1;
        guess_player = p;
        guess_char   = c;
        tick();
        guess_valid  = 1'b0;
    endtask

    // Full accepted guess: offer, then one more edge for the result.
    task automatic guess(input logic [PW-1:0] p, input logic [7:0] c);
        offer(p, c);
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        nRst         = 1'b1;
        word_load    = 1'b0;
        word_in      = '0;
        guess_valid  = 1'b0;
        guess_player = '0;
        guess_char   = '0;

        // Reset state
        tick(); tick();
        chk("rst_state",   state_dbg, 0);
        chk("rst_ready",   guess_ready, 0);
        chk("rst_turn",    turn, 0);
        chk("rst_reveal",  revealed, 0);
        chk("rst_counts",  {miss_count, hit_count}, 0);
        chk("rst_result",  {win, lose, winner}, 0);
        chk_pulses("rst_pulses", 4'b0000);
        nRst = 1'b0;

        // IDLE ignores guesses, no reject
        offer(2'd0, "A");
        chk_pulses("idle_guess", 4'b0000);
        chk("idle_state", state_dbg, 0);

        // Load APPLE
        load(w5("A", "P", "P", "L", "E"));
        chk("load_state",  state_dbg, 1);
        chk("load_ready",  guess_ready, 1);
        chk("load_reveal", revealed, 5'b00000);

        // Wrong player -> reject only
        offer(2'd1, "P");
        chk_pulses("wrong_player", 4'b0001);
        chk("wrong_player_turn", turn, 0);
        chk("wrong_player_cnt",  {revealed, miss_count, hit_count}, 0);
        chk("wrong_player_st",   state_dbg, 1);
        tick();
        chk_pulses("reject_1cyc", 4'b0000);

        // Out-of-range player index -> reject
        offer(2'd3, "P");
        chk_pulses("bad_player_idx", 4'b0001);

        // Player 0 guesses P: hit two edges after the offer
        offer(2'd0, "P");
        chk("check_state", state_dbg, 2);
        chk("check_ready", guess_ready, 0);
        chk_pulses("hit_latency", 4'b0000);
        tick();
        chk_pulses("hit_pulse", 4'b1000);
        chk("hit_reveal", revealed, 5'b00110);
        chk("hit_count1", hit_count, 1);
        chk("hit_turn",   turn, 1);
        tick();
        chk_pulses("hit_1cyc", 4'b0000);

        // Duplicate P by player 1
        guess(2'd1, "P");
        chk_pulses("dup_pulse", 4'b0010);
        chk("dup_hits", hit_count, 1);
        chk("dup_turn", turn, 1);
        chk("dup_miss", miss_count, 0);

        // Lowercase rejected
        offer(2'd1, "a");
        chk_pulses("lowercase", 4'b0001);

        // Miss by player 1
        guess(2'd1, "Z");
        chk_pulses("miss_pulse", 4'b0100);
        chk("miss_cnt1", miss_count, 1);
        chk("miss_turn", turn, 2);

        // word_load together with guess_valid: load wins, guess dropped
        word_load    = 1'b1;
        word_in      = w5("A", "P", "P", "L", "E");
        guess_valid  = 1'b1;
        guess_player = 2'd2;
        guess_char   = "A";
        tick();
        word_load   = 1'b0;
        guess_valid = 1'b0;
        chk("coload_state", state_dbg, 1);
        chk("coload_clear", {turn, revealed, miss_count, hit_count}, 0);
        chk_pulses("coload_p0", 4'b0000);
        tick();
        chk_pulses("coload_p1", 4'b0000);
        chk("coload_state2", state_dbg, 1);

        // Six misses -> lose
        guess(2'd0, "B");
        guess(2'd1, "C");
        guess(2'd2, "D");
        guess(2'd0, "F");
        guess(2'd1, "G");
        chk("miss_cnt5", miss_count, 5);
        chk("not_lost5", {lose, state_dbg}, {1'b0, 2'd1});
        guess(2'd2, "H");
        chk_pulses("miss6_pulse", 4'b0100);
        chk("miss_cnt6", miss_count, 6);
        chk("lose_flag", lose, 1);
        chk("lose_win",  {win, winner}, 0);
        chk("lose_state", state_dbg, 3);
        chk("lose_ready", guess_ready, 0);
        guess(2'd0, "A");
        chk_pulses("done_ignore", 4'b0000);
        chk("done_hold", {lose, miss_count, revealed}, {1'b1, 3'd6, 5'd0});

        // Win with wrap 2 -> 0
        load(w5("A", "P", "P", "L", "E"));
        guess(2'd0, "A");
        chk("win_rev_a", revealed, 5'b00001);
        guess(2'd1, "P");
        chk("win_rev_p", revealed, 5'b00111);
        guess(2'd2, "L");
        chk("wrap_turn", turn, 0);
        chk("win_rev_l", revealed, 5'b01111);
        guess(2'd0, "E");
        chk_pulses("win_hit", 4'b1000);
        chk("win_flags", {win, lose, winner}, {1'b1, 1'b0, 2'd0});
        chk("win_state", state_dbg, 3);
        chk("win_hits",  hit_count, 4);

        // Pre-revealed spaces, winner is player 1
        load(w5("A", " ", " ", " ", "B"));
        chk("prereveal", revealed, 5'b01110);
        guess(2'd0, "A");
        guess(2'd1, "B");
        chk("win_p1", {win, lose, winner}, {1'b1, 1'b0, 2'd1});

        // All-non-letter word: PLAY then DONE win, winner 0
        load(w5(" ", "-", "1", ".", " "));
        chk("nonletter_play", {state_dbg, win, winner}, {2'd1, 1'b0, 2'd0});
        chk("nonletter_rev", revealed, 5'b11111);
        tick();
        chk("nonletter_done", {state_dbg, win, lose, winner}, {2'd3, 1'b1, 1'b0, 2'd0});

        // Reset during CHECK discards the guess
        load(w5("A", "P", "P", "L", "E"));
        offer(2'd0, "P");
        chk("pre_rst_check", state_dbg, 2);
        nRst = 1'b1;
        tick();
        nRst = 1'b0;
        chk("midrst_state", state_dbg, 0);
        chk("midrst_clear", {turn, revealed, miss_count, hit_count}, 0);
        chk_pulses("midrst_p0", 4'b0000);
        tick();
        chk_pulses("midrst_p1", 4'b0000);
        chk("midrst_idle", state_dbg, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
